// File: rtl/tdm_demux_16.sv
// tdm_demux_16: 1-to-16 TDM serial demultiplexer rebuilding a parallel frame
// clk, rst_n        : rising-edge clock, asynchronous active-low reset
// din, din_valid    : serial slot bit and its qualifier
// frame_start       : marks the current valid bit as slot 0
// dout, dout_valid  : assembled frame (bit k = slot k) held until dout_ready
// dout_ready        : consumer accepts dout when dout_valid && dout_ready
// slot, busy        : next expected slot index, receiver is in sync
// frame_err         : one-cycle pulse when frame_start resyncs mid-frame
// overrun           : one-cycle pulse when a completed frame is dropped
module tdm_demux_16 #(
  parameter int NUM_CH = 16,
  parameter int SEL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              din_valid,
  input  logic              frame_start,
  output logic [NUM_CH-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [SEL_W-1:0]  slot,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);
  typedef enum logic {IDLE, RECV} state_t;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);
  state_t            state;
  logic [NUM_CH-2:0] shadow;
  logic              start, wr, commit;
  // Slot 0 is (re)established by frame_start whenever we are not already at slot 0.
  assign start  = din_valid && frame_start && (state == IDLE || slot != '0);
  assign wr     = din_valid && state == RECV && !start;
  // The last slot bit goes straight from din into dout; shadow only holds the first 15.
  assign commit = wr && slot == LAST;
  assign busy   = state == RECV;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      slot       <= '0;
      shadow     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= start && state == RECV;
      overrun   <= commit && dout_valid && !dout_ready;
      if (start) begin
        shadow[0] <= din;
        slot      <= SEL_W'(1);
        state     <= RECV;
      end else if (wr) begin
        if (slot != LAST) shadow[slot] <= din;
        slot <= slot + SEL_W'(1);
      end
      if (commit && (!dout_valid || dout_ready)) begin
        dout       <= {din, shadow};
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tdm_demux_16.sv
// tb_tdm_demux_16: randomized and directed checking of tdm_demux_16 against a frame-level model
module tb_tdm_demux_16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0, din_valid = 1'b0, frame_start = 1'b0, dout_ready = 1'b0;
  logic [15:0] dout;
  logic        dout_valid, busy, frame_err, overrun;
  logic [3:0]  slot;
  int          vectors = 0, miscompares = 0, err_seen = 0;
  bit          m_sync = 0, e_valid = 0, e_err = 0, e_ovr = 0;
  int          m_idx = 0;
  logic [15:0] m_frm = '0, e_dout = '0;

  tdm_demux_16 dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_start(frame_start),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .slot(slot),
    .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  // Frame-level model: a sync flag, a slot counter and a bit buffer, with a one-deep output holder.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_sync = 0; m_idx = 0; m_frm = '0; e_dout = '0; e_valid = 0; e_err = 0; e_ovr = 0;
    end else begin
      bit done, rdy;
      done = 0; rdy = dout_ready; e_err = 0; e_ovr = 0;
      if (din_valid) begin
        if (frame_start) begin
          if (m_sync && m_idx != 0) e_err = 1;
          m_sync = 1; m_idx = 0;
        end
        if (m_sync) begin
          m_frm[m_idx] = din;
          m_idx++;
          if (m_idx == 16) begin done = 1; m_idx = 0; end
        end
      end
      if (done) begin
        if (!e_valid || rdy) begin e_dout = m_frm; e_valid = 1; end
        else e_ovr = 1;
      end else if (e_valid && rdy) e_valid = 0;
    end
  end

  always @(negedge clk) begin
    chk("dout", dout, e_dout);
    chk("dout_valid", 16'(dout_valid), 16'(e_valid));
    chk("slot", 16'(slot), 16'(m_idx));
    chk("busy", 16'(busy), 16'(m_sync));
    chk("frame_err", 16'(frame_err), 16'(e_err));
    chk("overrun", 16'(overrun), 16'(e_ovr));
    if (frame_err) err_seen++;
  end

  task automatic drive(input logic v, input logic d, input logic fs, input logic rdy);
    @(negedge clk);
    din_valid = v; din = d; frame_start = fs; dout_ready = rdy;
  endtask

  task automatic send_frame(input logic [15:0] w, input logic fs, input logic rdy, input int gaps);
    int g = gaps;
    for (int k = 0; k < 16; k++) begin
      if (g > 0 && k > 0 && $urandom_range(0, 3) == 0) begin
        drive(0, 1'b1, 1'b1, rdy);
        g--;
      end
      drive(1, w[k], fs && k == 0, rdy);
    end
    for (; g > 0; g--) drive(0, 1'b0, 1'b1, rdy);
  endtask

  initial begin
    int t0;
    repeat (2) @(negedge clk);
    chk("reset_dout", dout, 16'h0000);
    chk("reset_valid", 16'(dout_valid), 16'h0);
    rst_n = 1'b1;
    send_frame(16'hA5C3, 1, 1, 0);
    drive(0, 0, 0, 1); #1;
    chk("a5c3_dout", dout, 16'hA5C3);
    chk("a5c3_valid", 16'(dout_valid), 16'h1);
    chk("a5c3_slot", 16'(slot), 16'h0);
    drive(0, 0, 0, 1); #1;
    chk("a5c3_valid_drop", 16'(dout_valid), 16'h0);
    t0 = vectors;
    send_frame(16'hA5C3, 1, 1, 3);
    drive(0, 0, 0, 1); #1;
    chk("gap_dout", dout, 16'hA5C3);
    send_frame(16'h1234, 1, 0, 0);
    send_frame(16'hFFFF, 1, 0, 0);
    drive(0, 0, 0, 0); #1;
    chk("ovr_pulse", 16'(overrun), 16'h1);
    chk("ovr_dout", dout, 16'h1234);
    chk("ovr_valid", 16'(dout_valid), 16'h1);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1); #1;
    chk("ovr_drained", 16'(dout_valid), 16'h0);
    err_seen = 0;
    for (int k = 0; k < 7; k++) drive(1, k[0], k == 0, 1);
    send_frame(16'h00F0, 1, 1, 0);
    drive(0, 0, 0, 1); #1;
    chk("resync_dout", dout, 16'h00F0);
    drive(0, 0, 0, 1); #1;
    chk("resync_err_count", 16'(err_seen), 16'h1);
    for (int k = 0; k < 9; k++) drive(1, 1'b1, k == 0, 0);
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    chk("async_dout", dout, 16'h0000);
    chk("async_valid", 16'(dout_valid), 16'h0);
    chk("async_slot", 16'(slot), 16'h0);
    chk("async_busy", 16'(busy), 16'h0);
    drive(0, 0, 0, 1);
    rst_n = 1'b1;
    send_frame(16'h8001, 1, 1, 0);
    drive(0, 0, 0, 1); #1;
    chk("post_reset_dout", dout, 16'h8001);
    @(posedge clk); #2;
    rst_n = 1'b0;
    drive(0, 0, 0, 1);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) drive(1, k[0], 0, 1);
    drive(0, 0, 0, 1); #1;
    chk("idle_valid", 16'(dout_valid), 16'h0);
    chk("idle_slot", 16'(slot), 16'h0);
    chk("idle_busy", 16'(busy), 16'h0);
    for (int k = 0; k < 600; k++)
      drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
    for (int k = 0; k < 8; k++) send_frame(16'($urandom), $urandom_range(0, 1) == 1, 1'($urandom), 2);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    if (vectors == t0) miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
